// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver with period-aligned double-buffered duties.
// Optional GAMMA_EN macro squares the intensity on load: (x*x+255)>>8.

module rgb_pwm_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] pwm_cnt,
  input  logic [7:0] x,
  output logic       led
);
  logic [7:0] duty, duty_nxt;

`ifdef GAMMA_EN
  logic [15:0] sq;
  // 255*255 + 255 = 65280 still fits in 16 bits
  assign sq       = ({8'd0, x} * {8'd0, x}) + 16'd255;
  assign duty_nxt = sq[15:8];
`else
  assign duty_nxt = x;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty <= '0;
      led  <= 1'b0;
    end else if (!on) begin
      duty <= '0;
      led  <= 1'b0;
    end else begin
      if (load) duty <= duty_nxt;
      // compares against the duty of the period in flight; the wrap-cycle
      // compare sees pwm_cnt==255 so the pin is low on that cycle
      led <= run & (pwm_cnt < duty);
    end
  end
endmodule

module rgb_pwm_driver #(
  parameter int PRESCALE = 4,
  parameter int PRE_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       period_start
);
  localparam int NUM_LANES = 3;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [7:0]       pwm_cnt;
  logic             run, tick, wrap, load;

  logic [NUM_LANES-1:0][7:0] lvl;
  logic [NUM_LANES-1:0]      leds;

  assign tick = run & (pre_cnt == PRE_MAX);
  assign wrap = tick & (pwm_cnt == 8'hff);
  assign load = on & (~run | wrap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      run          <= 1'b0;
      period_start <= 1'b0;
    end else if (!on) begin
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      run          <= 1'b0;
      period_start <= 1'b0;
    end else begin
      run          <= 1'b1;
      period_start <= load;
      if (load) begin
        pre_cnt <= '0;
        pwm_cnt <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else if (run) begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  assign lvl = {b, g, r};

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      rgb_pwm_lane u_lane (
        .clk     (clk),
        .rst     (rst),
        .on      (on),
        .run     (run),
        .load    (load),
        .pwm_cnt (pwm_cnt),
        .x       (lvl[i]),
        .led     (leds[i])
      );
    end
  endgenerate

  assign led_r = leds[0];
  assign led_g = leds[1];
  assign led_b = leds[2];
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: PRESCALE=1 and PRESCALE=4 instances side by side.
module tb_rgb_pwm_driver;
  logic       clk = 1'b0;
  logic       rst, on;
  logic [7:0] r, g, b;
  logic [1:0] lr, lg, lb, ps;

  int n_tests = 0;
  int n_fail  = 0;

  rgb_pwm_driver #(.PRESCALE(1), .PRE_W(16)) dut1 (
    .clk(clk), .rst(rst), .on(on), .r(r), .g(g), .b(b),
    .led_r(lr[0]), .led_g(lg[0]), .led_b(lb[0]), .period_start(ps[0])
  );

  rgb_pwm_driver #(.PRESCALE(4), .PRE_W(2)) dut4 (
    .clk(clk), .rst(rst), .on(on), .r(r), .g(g), .b(b),
    .led_r(lr[1]), .led_g(lg[1]), .led_b(lb[1]), .period_start(ps[1])
  );

  always #5 clk = ~clk;

  function automatic int f(input int x);
`ifdef GAMMA_EN
    return (x * x + 255) >> 8;
`else
    return x;
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on the negedge where period_start is high; counts pin-high
  // samples until the next period_start (bounded), optionally changing r.
  task automatic measure(input int sel, input int chg_at, input logic [7:0] chg_val,
                         output int hr, output int hg, output int hb, output int len);
    hr = 0; hg = 0; hb = 0; len = 0;
    for (int i = 0; i < 1100; i++) begin
      hr += int'(lr[sel]);
      hg += int'(lg[sel]);
      hb += int'(lb[sel]);
      len++;
      if (i == chg_at) r = chg_val;
      @(negedge clk);
      if (ps[sel]) break;
    end
  endtask

  int hr, hg, hb, len;

  initial begin
    rst = 1'b1; on = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0;
    repeat (2) @(negedge clk);
    check("reset_outs_p1", int'({lr[0], lg[0], lb[0], ps[0]}), 0);
    check("reset_outs_p4", int'({lr[1], lg[1], lb[1], ps[1]}), 0);

    // first period, PRESCALE=1
    rst = 1'b0; on = 1'b1; r = 8'd64; g = 8'd0; b = 8'd255;
    @(negedge clk);
    check("first_ps", int'(ps), 3);
    measure(0, -1, 8'd0, hr, hg, hb, len);
    check("p1_r64_high", hr, f(64));
    check("p1_g0_high", hg, 0);
    check("p1_b255_high", hb, f(255));
    check("p1_period_len", len, 256);

    // r changes at pwm_cnt=10; current period keeps the old duty
    measure(0, 10, 8'd128, hr, hg, hb, len);
    check("dbuf_old_r", hr, f(64));
    check("dbuf_len", len, 256);
    measure(0, -1, 8'd0, hr, hg, hb, len);
    check("dbuf_new_r", hr, f(128));
    check("dbuf_new_len", len, 256);

    // drop on at pwm_cnt=30
    repeat (30) @(negedge clk);
    check("pre_drop_led_r", int'(lr[0]), 1);
    on = 1'b0;
    @(negedge clk);
    check("drop_leds", int'({lr[0], lg[0], lb[0], ps[0]}), 0);
    check("drop_pwm_cnt", int'(dut1.pwm_cnt), 0);
    repeat (5) @(negedge clk);
    check("idle_outs", int'({lr, lg, lb, ps}), 0);

    // re-enable with r=200
    on = 1'b1; r = 8'd200;
    @(negedge clk);
    check("reen_ps", int'(ps[0]), 1);
    measure(0, -1, 8'd0, hr, hg, hb, len);
    check("reen_r200_high", hr, f(200));
    check("reen_len", len, 256);

    // PRESCALE=4, r=10
    on = 1'b0;
    @(negedge clk);
    r = 8'd10; on = 1'b1;
    @(negedge clk);
    check("p4_ps", int'(ps[1]), 1);
    measure(1, -1, 8'd0, hr, hg, hb, len);
    check("p4_r10_high", hr, 4 * f(10));
    check("p4_g0_high", hg, 0);
    check("p4_b255_high", hb, 4 * f(255));
    check("p4_period_len", len, 1024);

    // async reset mid-period with pins high
    repeat (5) @(negedge clk);
    check("pre_rst_led_b", int'(lb), 3);
    #2 rst = 1'b1;
    #1 check("async_rst_outs", int'({lr, lg, lb, ps}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ps", int'(ps), 3);
    measure(0, -1, 8'd0, hr, hg, hb, len);
    check("post_rst_r_high", hr, f(10));
    check("post_rst_len", len, 256);

    // small / mid levels
    on = 1'b0;
    @(negedge clk);
    r = 8'd1; g = 8'd128; b = 8'd0; on = 1'b1;
    @(negedge clk);
    check("lvl_ps", int'(ps[0]), 1);
    measure(0, -1, 8'd0, hr, hg, hb, len);
    check("lvl_r1_high", hr, f(1));
    check("lvl_g128_high", hg, f(128));
    check("lvl_b0_high", hb, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
Downstream stage of controlunit. It consumes the 8-bit r/g/b intensity words and produces three PWM pin drives for the physical RGB LED. Duties are double-buffered: shadow registers reload only at PWM period boundaries, so intensity changes mid-period never cause glitches. The block runs on the same clk as controlunit and honours the same on enable.

Parameters:
PRESCALE, 4, clk cycles per PWM tick; legal range 1..65535.
PRE_W, 16, prescaler counter width; must satisfy 2**PRE_W >= PRESCALE.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
on  input  1  enable. Low forces the LEDs off and idles the counters.
r  input  8  red intensity from controlunit.
g  input  8  green intensity from controlunit.
b  input  8  blue intensity from controlunit.
led_r  output  1  red PWM drive, active-high.
led_g  output  1  green PWM drive, active-high.
led_b  output  1  blue PWM drive, active-high.
period_start  output  1  one-clk pulse marking the first cycle of each PWM period.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high (rst). While rst=1, all state is 0: pre_cnt, pwm_cnt, run, duty_r/g/b, led_r/g/b and period_start.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1.
  - tick = run & (pre_cnt==PRESCALE-1).
  - With PRESCALE=1, tick is asserted every run cycle.
- PWM counter: pwm_cnt is 8 bits and increments on tick. wrap = tick & (pwm_cnt==255), which returns pwm_cnt to 0.
- Period length: 256*PRESCALE clk cycles.
- run register: run <= on each edge.
- Load condition: load = on & (~run | wrap). On load:
  - duty_x <= f(x), capturing r/g/b as present that cycle.
  - pwm_cnt <= 0 and pre_cnt <= 0.
- period_start <= load, registered. It is high for exactly the first clk cycle of each period.
- Outputs:
  - led_x <= on & run & (pwm_cnt < duty_x).
  - The outputs are registered, so a pin lags its comparison by 1 clk.
  - duty 0 gives a pin that is always low.
  - duty 255 gives a pin that is high 255/256 of each period.
  - High time per period = duty*PRESCALE clk cycles.
- On deasserted (on=0): on the next edge pre_cnt, pwm_cnt, duty_x, led_x, period_start and run all go to 0. Counters stay idle while on=0.
- On re-asserted: the first edge with on=1 performs a load (since run=0), so a fresh period starts from 0 with the current r/g/b.
- Mid-period input changes: changes to r/g/b have no effect until the next load.
- Simultaneous wrap and on falling: on=0 has priority; no load occurs.
- Reset mid-period: outputs drop immediately (asynchronous). After release, the block behaves as on a power-up with on=0 history.

Optional Feature:
GAMMA_EN:
- Defined: f(x) = (x*x + 255) >> 8, using a 16-bit intermediate. This maps 0->0, 1->1, 128->64 and 255->255, and is monotonic. It is computed combinationally at load time and registered into duty_x.
- Undefined: f(x) = x, with no multiplier synthesised.

Test Plan:
- Async reset: assert rst mid-period with leds high -> all outputs 0 without waiting for a clk edge. Release with on=1 -> period_start pulses after the first edge.
- PRESCALE=1, on=1, r=64, g=0, b=255 -> per 256-cycle period, led_r high 64 cycles, led_g never high, led_b high 255 cycles. period_start spaced exactly 256 cycles apart.
- Double buffering: change r from 64 to 128 at pwm_cnt=10 -> the current period still gives 64 high cycles; the next period gives 128.
- Enable control, step 1: drop on at pwm_cnt=30 -> leds 0 and pwm_cnt 0 after the next edge.
- Enable control, step 2: raise on again with r=200 -> period_start one edge later; led_r high 200 cycles.
- PRESCALE=4, r=10 -> period 1024 cycles with led_r high 40 cycles. period_start every 1024 cycles.
- GAMMA_EN defined: r=128 -> 64 high ticks; r=1 -> 1 tick; r=255 -> 255 ticks; r=0 -> never high.
